// File: rtl/plic_claim_agent_if.sv
// APB4 initiator bus plus handler ID handshake for plic_claim_agent.
// master: agent side; slave: PLIC target and offload handler side.
interface plic_claim_agent_if #(
  parameter int IRQ_WIDTH = 5
);
  logic [31:0]          paddr;
  logic [2:0]           pprot;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [31:0]          pwdata;
  logic [3:0]           pstrb;
  logic                 pready;
  logic [31:0]          prdata;
  logic                 pslverr;
  logic [IRQ_WIDTH-1:0] id;
  logic                 id_valid;
  logic                 id_ready;
  logic                 done;

  modport master (
    output paddr, pprot, psel, penable,
    output pwrite, pwdata, pstrb,
    output id, id_valid,
    input  pready, prdata, pslverr,
    input  id_ready, done
  );

  modport slave (
    input  paddr, pprot, psel, penable,
    input  pwrite, pwdata, pstrb,
    input  id, id_valid,
    output pready, prdata, pslverr,
    output id_ready, done
  );
endinterface

// File: rtl/plic_claim_agent.sv
// Hardware PLIC claim/complete agent: claim ID over APB, dispatch, complete.
// Ports: clk_i, rst_i, en_i, irq_i, bus (APB + ID handshake), busy_o, err_o, cnt_o.
module plic_claim_agent #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          IRQ_WIDTH = 5,
  parameter int          HOLDOFF   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                irq_i,
  plic_claim_agent_if.master  bus,
  output logic                busy_o,
  output logic                err_o,
  output logic [15:0]         cnt_o
);

  localparam logic [31:0] CC_ADDR = BASE_ADDR + 32'h24;
  localparam logic [3:0]  HOLD_LD = 4'(HOLDOFF);

  typedef enum logic [2:0] {
    IDLE, C_SETUP, C_ACCESS, DISPATCH,
    WAIT_DONE, W_SETUP, W_ACCESS, HOLD
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IRQ_WIDTH-1:0] r_id;
  logic                 r_err;
  logic [15:0]          r_cnt;
  logic [3:0]           r_hold;
  logic                 w_rd_done;
  logic                 w_wr_done;
  logic                 w_spur;
  logic [31:0]          w_wdata;

  assign w_rd_done = (r_state == C_ACCESS) && bus.pready;
  assign w_wr_done = (r_state == W_ACCESS) && bus.pready;
  assign w_spur    = (bus.prdata[IRQ_WIDTH-1:0] == '0);
  assign w_wdata   = {{(32-IRQ_WIDTH){1'b0}}, r_id};

  assign bus.id = r_id;
  assign bus.pprot = 3'b000;
  assign busy_o = (r_state != IDLE);
  assign err_o = r_err;
  assign cnt_o = r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.psel     = 1'b0;
    bus.penable  = 1'b0;
    bus.pwrite   = 1'b0;
    bus.paddr    = '0;
    bus.pwdata   = '0;
    bus.pstrb    = 4'h0;
    bus.id_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en_i && irq_i && r_hold == '0)
          w_next = C_SETUP;
      end
      C_SETUP: begin
        bus.psel  = 1'b1;
        bus.paddr = CC_ADDR;
        w_next    = C_ACCESS;
      end
      C_ACCESS: begin
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        bus.paddr   = CC_ADDR;
        if (bus.pready) begin
          // error: drop the claim; ID 0: nothing pending
          if (bus.pslverr) w_next = IDLE;
          else if (w_spur) w_next = HOLD;
          else             w_next = DISPATCH;
        end
      end
      DISPATCH: begin
        bus.id_valid = 1'b1;
        if (bus.id_ready) w_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.done) w_next = W_SETUP;
      end
      W_SETUP: begin
        bus.psel   = 1'b1;
        bus.pwrite = 1'b1;
        bus.paddr  = CC_ADDR;
        bus.pwdata = w_wdata;
        bus.pstrb  = 4'hF;
        w_next     = W_ACCESS;
      end
      W_ACCESS: begin
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        bus.pwrite  = 1'b1;
        bus.paddr   = CC_ADDR;
        bus.pwdata  = w_wdata;
        bus.pstrb   = 4'hF;
        if (bus.pready) w_next = HOLD;
      end
      HOLD: begin
        if (r_hold == '0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id   <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
      r_hold <= '0;
    end else begin
      if ((w_rd_done || w_wr_done) && bus.pslverr)
        r_err <= 1'b1;
      if (w_rd_done && !bus.pslverr && !w_spur)
        r_id <= bus.prdata[IRQ_WIDTH-1:0];
      if (w_wr_done)
        r_cnt <= r_cnt + 16'd1;
      // holdoff lets the PLIC drop irq before re-sampling
      if (w_next == HOLD && r_state != HOLD)
        r_hold <= HOLD_LD;
      else if (r_state == HOLD && r_hold != '0)
        r_hold <= r_hold - 4'd1;
    end
  end

endmodule
